ternary_weight_buffer_pingpong: RTL and testbench

Double-buffered (ping-pong) ternary weight store for the matmul-free systolic array. It is the parametrised successor of the single-bank wide weight SRAM. Packed 2-bit ternary weights are written into a shadow bank while the active bank streams full rows (one distinct weight per array column) to the array under a valid/ready handshake. Banks exchange on a swap command, which is deferred safely while a stream is in flight.

---
 rtl/ternary_weight_buffer_pingpong_if.sv | 44 ++++
 rtl/ternary_weight_buffer_pingpong.sv | 183 ++++++++++++++++++
 tb/tb_ternary_weight_buffer_pingpong.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ternary_weight_buffer_pingpong_if.sv
// Bus bundle for the ping-pong ternary weight buffer.
// master: weight writer / stream consumer (drives write port, swap/start controls, out_ready).
// slave : the buffer (drives out, out_valid and the status flags).
// Signals:
//   wr_en/wr_addr/wr_data    shadow-bank write port (word address = row*WPR + slot)
//   swap, start              control pulses
//   rd_base, rd_len          stream window, sampled with start
//   out_valid/out_ready/out  row stream handshake, column 0 in out[0]
//   busy, done, active_bank, swap_pending, enc_err   status
interface ternary_weight_buffer_pingpong_if #(
  parameter int unsigned ARR_WIDTH = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned IN_WIDTH  = 8
);
  localparam int unsigned WPR  = 2 * ARR_WIDTH / IN_WIDTH;
  localparam int unsigned WA_W = $clog2(DEPTH * WPR);
  localparam int unsigned RA_W = $clog2(DEPTH);

  logic                               wr_en;
  logic        [WA_W-1:0]             wr_addr;
  logic        [IN_WIDTH-1:0]         wr_data;
  logic                               swap;
  logic                               start;
  logic        [RA_W-1:0]             rd_base;
  logic        [RA_W:0]               rd_len;
  logic                               out_ready;
  logic                               out_valid;
  logic signed [ARR_WIDTH-1:0][1:0]   out;
  logic                               busy;
  logic                               done;
  logic                               active_bank;
  logic                               swap_pending;
  logic                               enc_err;

  modport master (
    output wr_en, wr_addr, wr_data, swap, start, rd_base, rd_len, out_ready,
    input  out_valid, out, busy, done, active_bank, swap_pending, enc_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap, start, rd_base, rd_len, out_ready,
    output out_valid, out, busy, done, active_bank, swap_pending, enc_err
  );
endinterface

// File: rtl/ternary_weight_buffer_pingpong.sv
// Double-buffered ternary weight store. Packed 2-bit weights (00=0, 01=+1, 11=-1) are written
// into the shadow bank while the active bank streams whole rows to the array under
// valid/ready. A swap requested during a stream is held and applied on the done cycle.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   bus      slave side of ternary_weight_buffer_pingpong_if (write port, controls,
//            row stream and status flags)
module ternary_weight_buffer_pingpong #(
  parameter int unsigned ARR_WIDTH = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned IN_WIDTH  = 8
) (
  input logic                            clk_i,
  input logic                            reset_i,
  ternary_weight_buffer_pingpong_if.slave bus
);
  localparam int unsigned WPR    = 2 * ARR_WIDTH / IN_WIDTH;
  localparam int unsigned WA_W   = $clog2(DEPTH * WPR);
  localparam int unsigned RA_W   = $clog2(DEPTH);
  localparam int unsigned ROW_W  = 2 * ARR_WIDTH;
  localparam int unsigned NWORDS = DEPTH * WPR;
  localparam int unsigned SLOT_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int unsigned FPW    = IN_WIDTH / 2;
  localparam logic [RA_W:0] LenOne = {{RA_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

  // Bank storage, organised by write word so each write is one element update.
  logic [IN_WIDTH-1:0] mem_q [2][DEPTH][WPR];

  state_e                  state_q;
  logic [RA_W-1:0]         ptr_q;
  logic [RA_W:0]           fetch_left_q;  // rows not yet read from the bank
  logic [RA_W:0]           remain_q;      // rows not yet accepted by the consumer
  logic [ROW_W-1:0]        rd_data_q;     // prefetch stage
  logic                    rd_vld_q;
  logic [ARR_WIDTH-1:0][1:0] out_q;       // output stage
  logic                    out_valid_q;
  logic                    done_q;
  logic                    active_q;
  logic                    swap_pend_q;
  logic                    enc_err_q;

  // Write path: illegal 2'b10 fields are stored as zero and flagged.
  logic [IN_WIDTH-1:0] wr_clean;
  logic                wr_bad;
  logic                wr_ok;
  logic [RA_W-1:0]     wr_row;
  logic [SLOT_W-1:0]   wr_slot;
  logic                shadow;

  always_comb begin
    wr_clean = bus.wr_data;
    wr_bad   = 1'b0;
    for (int i = 0; i < FPW; i++) begin
      if (bus.wr_data[2*i +: 2] == 2'b10) begin
        wr_clean[2*i +: 2] = 2'b00;
        wr_bad             = 1'b1;
      end
    end
    wr_ok   = bus.wr_en && (32'(bus.wr_addr) < NWORDS);
    wr_row  = RA_W'(32'(bus.wr_addr) / WPR);
    wr_slot = SLOT_W'(32'(bus.wr_addr) % WPR);
    shadow  = ~active_q;
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[shadow][wr_row][wr_slot] <= wr_clean;
    end
  end

  // Two-stage read pipeline: the prefetch register refills in the same cycle it hands its
  // row to the output stage, giving one row per cycle under continuous ready.
  logic pop;
  logic s2_load;
  logic issue;

  always_comb begin
    pop     = out_valid_q && bus.out_ready;
    s2_load = rd_vld_q && (!out_valid_q || pop);
    issue   = (state_q != StIdle) && (fetch_left_q != '0) && (!rd_vld_q || s2_load);
  end

  always_ff @(posedge clk_i) begin
    if (issue) begin
      for (int k = 0; k < WPR; k++) begin
        rd_data_q[k*IN_WIDTH +: IN_WIDTH] <= mem_q[active_q][ptr_q][k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      fetch_left_q <= '0;
      remain_q     <= '0;
      rd_vld_q     <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      active_q     <= 1'b0;
      swap_pend_q  <= 1'b0;
      enc_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_ok && wr_bad) begin
        enc_err_q <= 1'b1;
      end

      if (issue) begin
        ptr_q        <= (ptr_q == RA_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        fetch_left_q <= fetch_left_q - 1'b1;
        rd_vld_q     <= 1'b1;
      end else if (s2_load) begin
        rd_vld_q <= 1'b0;
      end

      if (s2_load) begin
        out_q       <= rd_data_q;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          // Swap lands first so a same-edge start reads the new active bank.
          if (bus.swap) begin
            active_q <= ~active_q;
          end
          if (bus.start) begin
            if (bus.rd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= StFetch;
              ptr_q        <= bus.rd_base;
              fetch_left_q <= bus.rd_len;
              remain_q     <= bus.rd_len;
            end
          end
        end
        StFetch: begin
          if (bus.swap) begin
            swap_pend_q <= 1'b1;
          end
          if (s2_load) begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (pop && (remain_q == LenOne)) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            swap_pend_q <= 1'b0;
            if (swap_pend_q || bus.swap) begin
              active_q <= ~active_q;
            end
          end else begin
            if (pop) begin
              remain_q <= remain_q - 1'b1;
            end
            if (bus.swap) begin
              swap_pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out          = out_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;
  assign bus.active_bank  = active_q;
  assign bus.swap_pending = swap_pend_q;
  assign bus.enc_err      = enc_err_q;
endmodule

// File: tb/tb_ternary_weight_buffer_pingpong.sv
// Self-checking bench for ternary_weight_buffer_pingpong: per-cycle comparison against a
// behavioural model (weights held as integers per bank/row/column, stream as a queue of rows),
// a table of encode vectors, and directed burst / wrap / reset sequences.
module tb_ternary_weight_buffer_pingpong;
  localparam int unsigned ARR_WIDTH = 8;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned IN_WIDTH  = 8;
  localparam int unsigned WPR       = 2 * ARR_WIDTH / IN_WIDTH;
  localparam int unsigned WA_W      = $clog2(DEPTH * WPR);
  localparam int unsigned RA_W      = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ternary_weight_buffer_pingpong_if #(
    .ARR_WIDTH(ARR_WIDTH), .DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH)
  ) bus ();

  ternary_weight_buffer_pingpong #(
    .ARR_WIDTH(ARR_WIDTH), .DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  logic [2*ARR_WIDTH-1:0] out_flat;
  assign out_flat = bus.out;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int mw [2][DEPTH][ARR_WIDTH];
  int m_active = 0, m_pend = 0, m_err = 0, m_busy = 0, m_valid = 0, m_done = 0, m_wait = 0;
  int q_rows[$];

  function automatic logic [2*ARR_WIDTH-1:0] enc_row(input int b, input int r);
    logic [2*ARR_WIDTH-1:0] v;
    v = '0;
    for (int c = 0; c < ARR_WIDTH; c++)
      v[2*c +: 2] = (mw[b][r][c] == 1) ? 2'b01 : (mw[b][r][c] == -1) ? 2'b11 : 2'b00;
    return v;
  endfunction

  task automatic model_write(input int b, input int addr, input logic [IN_WIDTH-1:0] d);
    int row, slot;
    logic [IN_WIDTH-1:0] dd;
    logic [1:0] f;
    row = addr / WPR;
    slot = addr % WPR;
    dd = d;
    for (int i = 0; i < IN_WIDTH / 2; i++) begin
      f = dd[2*i +: 2];
      if (f == 2'b10) m_err = 1;
      mw[b][row][slot*IN_WIDTH/2 + i] = (f == 2'b01) ? 1 : (f == 2'b11) ? -1 : 0;
    end
  endtask

  // Advance model and DUT by one edge, then compare every visible output.
  task automatic tick();
    int pre_active;
    int hs;
    pre_active = m_active;
    hs = m_valid & int'(bus.out_ready);
    if (reset) begin
      m_active = 0; m_pend = 0; m_err = 0; m_busy = 0; m_valid = 0; m_done = 0; m_wait = 0;
      q_rows.delete();
    end else begin
      m_done = 0;
      if (bus.wr_en && int'(bus.wr_addr) < DEPTH * WPR)
        model_write(1 - pre_active, int'(bus.wr_addr), bus.wr_data);
      if (m_busy != 0) begin
        if (bus.swap) m_pend = 1;
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) m_valid = 1;
        end else if (hs != 0) begin
          void'(q_rows.pop_front());
          if (q_rows.size() == 0) begin
            m_busy = 0; m_valid = 0; m_done = 1;
            if (m_pend != 0) m_active = 1 - m_active;
            m_pend = 0;
          end
        end
      end else begin
        if (bus.swap) m_active = 1 - m_active;
        if (bus.start) begin
          if (bus.rd_len == 0) m_done = 1;
          else begin
            m_busy = 1; m_wait = 2;
            for (int i = 0; i < int'(bus.rd_len); i++)
              q_rows.push_back((int'(bus.rd_base) + i) % DEPTH);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("active_bank", 32'(bus.active_bank), 32'(m_active));
    chk("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
    chk("enc_err", 32'(bus.enc_err), 32'(m_err));
    if (m_valid != 0 && q_rows.size() > 0)
      chk("row", 32'(out_flat), 32'(enc_row(m_active, q_rows[0])));
  endtask

  task automatic wr(input int addr, input logic [IN_WIDTH-1:0] data);
    bus.wr_en = 1'b1;
    bus.wr_addr = WA_W'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_swap();
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
  endtask

  function automatic logic [IN_WIDTH-1:0] legal_word();
    logic [IN_WIDTH-1:0] w;
    int f;
    for (int i = 0; i < IN_WIDTH / 2; i++) begin
      f = int'($urandom_range(0, 2));
      w[2*i +: 2] = (f == 2) ? 2'b11 : 2'(f);
    end
    return w;
  endfunction

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] exp_row;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];
  logic [15:0] bpat [4];
  logic [15:0] wpat [4];

  initial begin
    int tbl_bank;
    int nacc, ndone;
    bit swapped, did_swap_now, have_stall, rdy;
    logic [15:0] stall_val;

    vecs[0] = '{8'h13, 8'hC4, 16'hC413, 1'b0};
    vecs[1] = '{8'h5F, 8'hFF, 16'hFF5F, 1'b0};
    vecs[2] = '{8'h55, 8'h00, 16'h0055, 1'b0};
    vecs[3] = '{8'h02, 8'h13, 16'h1300, 1'b1};
    vecs[4] = '{8'h6B, 8'hAA, 16'h0043, 1'b1};
    vecs[5] = '{8'h40, 8'h3C, 16'h3C40, 1'b1};
    bpat = '{16'h0301, 16'h300C, 16'h44C0, 16'hFF55};
    wpat = '{16'h0113, 16'hC4C4, 16'h3311, 16'h0F0D};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.swap = 1'b0; bus.start = 1'b0;
    bus.rd_base = '0; bus.rd_len = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(out_flat), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_active", 32'(bus.active_bank), 32'd0);
    chk("rst_enc_err", 32'(bus.enc_err), 32'd0);
    reset = 1'b0;

    // Fill both banks with legal weights so every row has defined contents.
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < DEPTH * WPR; a++) wr(a, legal_word());
      do_swap();
    end

    // Table: write row 0 of shadow, swap, stream it and compare.
    tbl_bank = 0;
    for (int v = 0; v < 6; v++) begin
      wr(0, vecs[v].w0);
      wr(1, vecs[v].w1);
      do_swap();
      tbl_bank ^= 1;
      chk("tbl_bank", 32'(bus.active_bank), 32'(tbl_bank));
      bus.start = 1'b1; bus.rd_base = '0; bus.rd_len = 8'd1; bus.out_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("tbl_valid_early", 32'(bus.out_valid), 32'd0);
      tick();
      chk("tbl_valid", 32'(bus.out_valid), 32'd1);
      chk("tbl_row", 32'(out_flat), 32'(vecs[v].exp_row));
      tick();
      chk("tbl_done", 32'(bus.done), 32'd1);
      chk("tbl_enc_err", 32'(bus.enc_err), 32'(vecs[v].exp_err));
    end
    tick();
    chk("err_sticky", 32'(bus.enc_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 32'(bus.enc_err), 32'd0);

    // Burst with backpressure and a deferred swap.
    for (int r = 0; r < 4; r++) begin
      wr((2 + r) * 2, bpat[r][7:0]);
      wr((2 + r) * 2 + 1, bpat[r][15:8]);
    end
    do_swap();
    bus.start = 1'b1; bus.rd_base = 7'd2; bus.rd_len = 8'd4; bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    nacc = 0; ndone = 0; swapped = 0; did_swap_now = 0; have_stall = 0; stall_val = '0;
    for (int c = 0; c < 30; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      bus.out_ready = rdy;
      if (have_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_stable", 32'(out_flat), 32'(stall_val));
      end
      have_stall = 0;
      if (bus.out_valid && rdy) begin
        if (nacc < 4) chk("burst_row", 32'(out_flat), 32'(bpat[nacc]));
        nacc++;
      end else if (bus.out_valid) begin
        have_stall = 1;
        stall_val = out_flat;
      end
      if (nacc == 1 && !swapped) begin
        bus.swap = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 8'd6; bus.wr_data = 8'hFF;
        swapped = 1; did_swap_now = 1;
      end
      tick();
      bus.swap = 1'b0; bus.wr_en = 1'b0;
      if (did_swap_now) begin
        chk("pend_set", 32'(bus.swap_pending), 32'd1);
        chk("bank_held", 32'(bus.active_bank), 32'd1);
        did_swap_now = 0;
      end
      if (bus.done) begin
        ndone++;
        chk("swap_at_done", 32'(bus.active_bank), 32'd0);
        chk("pend_clear", 32'(bus.swap_pending), 32'd0);
      end
    end
    chk("burst_count", 32'(nacc), 32'd4);
    chk("burst_dones", 32'(ndone), 32'd1);

    // Wrap-around from row DEPTH-2.
    wr(252, wpat[0][7:0]); wr(253, wpat[0][15:8]);
    wr(254, wpat[1][7:0]); wr(255, wpat[1][15:8]);
    wr(0, wpat[2][7:0]);   wr(1, wpat[2][15:8]);
    wr(2, wpat[3][7:0]);   wr(3, wpat[3][15:8]);
    do_swap();
    bus.start = 1'b1; bus.rd_base = 7'(DEPTH - 2); bus.rd_len = 8'd4; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) begin
        if (nacc < 4) chk("wrap_row", 32'(out_flat), 32'(wpat[nacc]));
        nacc++;
      end
      tick();
    end
    chk("wrap_count", 32'(nacc), 32'd4);

    // Reset in the middle of a stream with a swap pending.
    bus.start = 1'b1; bus.rd_base = '0; bus.rd_len = 8'd8; bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5 && !bus.out_valid; i++) tick();
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    do_swap();
    chk("mid_pend", 32'(bus.swap_pending), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_pend", 32'(bus.swap_pending), 32'd0);
    chk("rst_mid_active", 32'(bus.active_bank), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    tick();
    chk("rst_no_done", 32'(bus.done), 32'd0);
    bus.start = 1'b1; bus.rd_len = '0;
    tick();
    bus.start = 1'b0;
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("len0_done_pulse", 32'(bus.done), 32'd0);
    chk("len0_valid_after", 32'(bus.out_valid), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = WA_W'($urandom_range(0, DEPTH * WPR - 1));
      bus.wr_data   = IN_WIDTH'($urandom);
      bus.swap      = ($urandom_range(0, 29) == 0);
      bus.start     = ($urandom_range(0, 11) == 0);
      bus.rd_base   = RA_W'($urandom_range(0, DEPTH - 1));
      bus.rd_len    = ($urandom_range(0, 9) == 0) ? (RA_W+1)'(DEPTH)
                                                  : (RA_W+1)'($urandom_range(0, 9));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.wr_en = 1'b0; bus.swap = 1'b0; bus.start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
